// File: rtl/tetris_field_pkg.sv
// Shared definitions for the Tetris playfield controller: state encoding,
// line-clear combo table and grid index helper.
package tetris_field_pkg;

    localparam logic [6:0] ST_INI   = 7'b0000001;
    localparam logic [6:0] ST_GEN   = 7'b0000010;
    localparam logic [6:0] ST_MOVE  = 7'b0000100;
    localparam logic [6:0] ST_LOCK  = 7'b0001000;
    localparam logic [6:0] ST_CLEAR = 7'b0010000;
    localparam logic [6:0] ST_SCORE = 7'b0100000;
    localparam logic [6:0] ST_LOST  = 7'b1000000;

    // Multiplier of the base line score, indexed by lines cleared in one lock.
    localparam logic [4:0][3:0] COMBO_TBL = {4'd8, 4'd5, 4'd3, 4'd1, 4'd0};

    function automatic logic [3:0] combo_mult(input logic [4:0] k);
        logic [2:0] idx;
        idx = (k > 5'd4) ? 3'd4 : k[2:0];
        return COMBO_TBL[idx];
    endfunction

    function automatic int unsigned flat_idx(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/tetris_field_row_shift.sv
// Removes one row from the grid: rows above it drop by one and an empty
// row enters at the top.
module field_row_shift
    import tetris_field_pkg::*;
#(
    parameter int unsigned COLS = 10,
    parameter int unsigned ROWS = 12
) (
    input  logic [COLS*ROWS-1:0] field_in,
    input  logic [3:0]           row,
    output logic [COLS*ROWS-1:0] field_out
);

    always_comb begin
        field_out = '0;
        for (int unsigned j = 0; j < ROWS; j++) begin
            if (32'(row) > j)
                field_out[flat_idx(j, 0, COLS) +: COLS] = field_in[flat_idx(j, 0, COLS) +: COLS];
            else if (j < ROWS - 1)
                field_out[flat_idx(j, 0, COLS) +: COLS] = field_in[flat_idx(j + 1, 0, COLS) +: COLS];
        end
    end

endmodule

// File: rtl/tetris_field.sv
// Tetris playfield controller: occupancy grid, piece commit with top-out
// detection, multi-row clearing with gravity, score and line count.
module tetris_field
    import tetris_field_pkg::*;
#(
    parameter int unsigned COLS     = 10,
    parameter int unsigned ROWS     = 12,
    parameter int unsigned SCORE_W  = 16,
    parameter int unsigned LINE_PTS = 10
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Ack,
    input  logic                 lock_req,
    input  logic                 top_flag,
    input  logic [15:0]          cell_x,
    input  logic [15:0]          cell_y,
    output logic [COLS*ROWS-1:0] field,
    output logic [6:0]           state,
    output logic                 gen_flag,
    output logic                 started,
    output logic                 busy,
    output logic [SCORE_W-1:0]   score,
    output logic [15:0]          lines
);

    localparam int unsigned FW       = COLS * ROWS;
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

    logic [6:0]         next_state;
    logic [15:0]        lock_x, lock_y;
    logic [4:0]         r;
    logic [4:0]         k;
    logic [FW-1:0]      lock_mask;
    logic [FW-1:0]      shifted;
    logic [3:0]         cx, cy;
    logic               overlap;
    logic               row_full;
    logic [SCORE_W:0]   addend;
    logic [SCORE_W:0]   score_sum;
    logic [16:0]        lines_sum;

    assign gen_flag = (state == ST_GEN);
    assign started  = (state != ST_INI);
    assign busy     = (state == ST_LOCK) || (state == ST_CLEAR) || (state == ST_SCORE);

    // Out-of-range cells contribute nothing; duplicates simply OR together.
    always_comb begin
        lock_mask = '0;
        cx        = '0;
        cy        = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            cx = lock_x[4*i +: 4];
            cy = lock_y[4*i +: 4];
            if (32'(cx) < COLS && 32'(cy) < ROWS)
                lock_mask = lock_mask | (FW'(1) << flat_idx(32'(cy), 32'(cx), COLS));
        end
    end

    assign overlap = |(lock_mask & field);

    always_comb begin
        row_full = 1'b0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (r == 5'(i))
                row_full = &field[flat_idx(i, 0, COLS) +: COLS];
        end
    end

    field_row_shift #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_row_shift (
        .field_in (field),
        .row      (r[3:0]),
        .field_out(shifted)
    );

    assign addend    = (SCORE_W + 1)'(LINE_PTS * 32'(combo_mult(k)));
    assign score_sum = {1'b0, score} + addend;
    assign lines_sum = {1'b0, lines} + 17'(k);

    always_comb begin
        next_state = state;
        case (state)
            ST_INI:   if (Start) next_state = ST_GEN;
            ST_GEN:   next_state = ST_MOVE;
            ST_MOVE: begin
                if (top_flag)      next_state = ST_LOST;
                else if (lock_req) next_state = ST_LOCK;
            end
            ST_LOCK:  next_state = overlap ? ST_LOST : ST_CLEAR;
            ST_CLEAR: if (!row_full && r == LAST_ROW) next_state = ST_SCORE;
            ST_SCORE: next_state = ST_GEN;
            ST_LOST:  if (Ack) next_state = ST_INI;
            default:  next_state = ST_INI;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= ST_INI;
            field  <= '0;
            score  <= '0;
            lines  <= '0;
            k      <= '0;
            r      <= '0;
            lock_x <= '0;
            lock_y <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_INI: begin
                    field <= '0;
                    score <= '0;
                    lines <= '0;
                    k     <= '0;
                end
                ST_MOVE: begin
                    if (!top_flag && lock_req) begin
                        lock_x <= cell_x;
                        lock_y <= cell_y;
                    end
                end
                ST_LOCK: begin
                    if (!overlap) begin
                        field <= field | lock_mask;
                        r     <= '0;
                        k     <= '0;
                    end
                end
                // Holding r after a clear re-examines the row that just dropped in.
                ST_CLEAR: begin
                    if (row_full) begin
                        field <= shifted;
                        k     <= k + 5'd1;
                    end else begin
                        r <= r + 5'd1;
                    end
                end
                ST_SCORE: begin
                    score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    lines <= lines_sum[16] ? '1 : lines_sum[15:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_field.sv
// Directed bench for tetris_field: table of piece locks with hand-computed
// grids, plus sequences for LOST/Ack, Start and reset during a clear.
module tb_tetris_field;
    import tetris_field_pkg::*;

    localparam int unsigned COLS = 10;
    localparam int unsigned ROWS = 12;
    localparam int unsigned FW   = COLS * ROWS;

    logic          Clk = 1'b0;
    logic          Reset, Start, Ack, lock_req, top_flag;
    logic [15:0]   cell_x, cell_y;
    logic [FW-1:0] field;
    logic [6:0]    state;
    logic          gen_flag, started, busy;
    logic [15:0]   score, lines;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0]   cx;
        logic [15:0]   cy;
        logic [FW-1:0] exp_field;
        logic [15:0]   exp_score;
        logic [15:0]   exp_lines;
        logic          exp_lost;
        int            exp_cycles;
    } vec_t;

    vec_t vecs[20];

    tetris_field #(
        .COLS(COLS),
        .ROWS(ROWS),
        .SCORE_W(16),
        .LINE_PTS(10)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
        .lock_req(lock_req), .top_flag(top_flag),
        .cell_x(cell_x), .cell_y(cell_y),
        .field(field), .state(state), .gen_flag(gen_flag),
        .started(started), .busy(busy), .score(score), .lines(lines)
    );

    always #5 Clk = ~Clk;

    function automatic logic [FW-1:0] rm(input int row, input logic [9:0] m);
        logic [FW-1:0] v;
        v = FW'(m);
        return v << (row * COLS);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input int i);
        int n;
        chk($sformatf("v%0d_in_move", i), 128'(state), 128'(ST_MOVE));
        cell_x   = vecs[i].cx;
        cell_y   = vecs[i].cy;
        lock_req = 1'b1;
        n        = 0;
        do begin
            @(negedge Clk);
            n++;
            lock_req = 1'b0;
            if (n == 1) begin
                chk($sformatf("v%0d_lock_state", i), 128'(state), 128'(ST_LOCK));
                chk($sformatf("v%0d_lock_busy", i), 128'(busy), 128'(1'b1));
            end
        end while (!gen_flag && state !== ST_LOST && n < 64);
        chk($sformatf("v%0d_cycles", i), 128'(n), 128'(vecs[i].exp_cycles));
        chk($sformatf("v%0d_lost", i), 128'(state == ST_LOST), 128'(vecs[i].exp_lost));
        chk($sformatf("v%0d_field", i), 128'(field), 128'(vecs[i].exp_field));
        chk($sformatf("v%0d_score", i), 128'(score), 128'(vecs[i].exp_score));
        chk($sformatf("v%0d_lines", i), 128'(lines), 128'(vecs[i].exp_lines));
        if (!vecs[i].exp_lost) @(negedge Clk);
    endtask

    task automatic do_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("gen_state", 128'(state), 128'(ST_GEN));
        chk("gen_flag", 128'(gen_flag), 128'(1'b1));
        chk("gen_started", 128'(started), 128'(1'b1));
        @(negedge Clk);
        chk("move_gen_low", 128'(gen_flag), 128'(1'b0));
    endtask

    initial begin
        logic [FW-1:0] b;
        b = rm(5, 10'h007) | rm(6, 10'h060);
        vecs[0]  = '{16'h3210, 16'h0000, rm(0, 10'h00F), 16'd0, 16'd0, 1'b0, 15};
        vecs[1]  = '{16'h7654, 16'h0000, rm(0, 10'h0FF), 16'd0, 16'd0, 1'b0, 15};
        vecs[2]  = '{16'h9898, 16'h1100, rm(0, 10'h300), 16'd10, 16'd1, 1'b0, 16};
        vecs[3]  = '{16'h0008, 16'h7650, rm(0, 10'h300), 16'd10, 16'd1, 1'b1, 2};
        vecs[4]  = '{16'h3210, 16'h0000, rm(0, 10'h00F), 16'd0, 16'd0, 1'b0, 15};
        vecs[5]  = '{16'h7654, 16'h0000, rm(0, 10'h0FF), 16'd0, 16'd0, 1'b0, 15};
        vecs[6]  = '{16'h3210, 16'h1111, rm(0, 10'h0FF) | rm(1, 10'h00F), 16'd0, 16'd0, 1'b0, 15};
        vecs[7]  = '{16'h7654, 16'h1111, rm(0, 10'h0FF) | rm(1, 10'h0FF), 16'd0, 16'd0, 1'b0, 15};
        vecs[8]  = '{16'h3210, 16'h2222, rm(0, 10'h0FF) | rm(1, 10'h0FF) | rm(2, 10'h00F),
                     16'd0, 16'd0, 1'b0, 15};
        vecs[9]  = '{16'h7654, 16'h2222, rm(0, 10'h0FF) | rm(1, 10'h0FF) | rm(2, 10'h0FF),
                     16'd0, 16'd0, 1'b0, 15};
        vecs[10] = '{16'h3210, 16'h3333, rm(0, 10'h0FF) | rm(1, 10'h0FF) | rm(2, 10'h0FF)
                     | rm(3, 10'h00F), 16'd0, 16'd0, 1'b0, 15};
        vecs[11] = '{16'h7654, 16'h3333, rm(0, 10'h0FF) | rm(1, 10'h0FF) | rm(2, 10'h0FF)
                     | rm(3, 10'h0FF), 16'd0, 16'd0, 1'b0, 15};
        vecs[12] = '{16'h8888, 16'h3210, rm(0, 10'h1FF) | rm(1, 10'h1FF) | rm(2, 10'h1FF)
                     | rm(3, 10'h1FF), 16'd0, 16'd0, 1'b0, 15};
        vecs[13] = '{16'h9999, 16'h3210, '0, 16'd80, 16'd4, 1'b0, 19};
        vecs[14] = '{16'h3210, 16'hF555, rm(5, 10'h007), 16'd80, 16'd4, 1'b0, 15};
        vecs[15] = '{16'hA655, 16'h6666, b, 16'd80, 16'd4, 1'b0, 15};
        vecs[16] = '{16'h3210, 16'h0000, b | rm(0, 10'h00F), 16'd80, 16'd4, 1'b0, 15};
        vecs[17] = '{16'h7654, 16'h0000, b | rm(0, 10'h0FF), 16'd80, 16'd4, 1'b0, 15};
        vecs[18] = '{16'h3210, 16'h1111, b | rm(0, 10'h0FF) | rm(1, 10'h00F), 16'd80, 16'd4, 1'b0, 15};
        vecs[19] = '{16'h7654, 16'h1111, b | rm(0, 10'h0FF) | rm(1, 10'h0FF), 16'd80, 16'd4, 1'b0, 15};

        Reset = 1'b1; Start = 1'b0; Ack = 1'b0; lock_req = 1'b0; top_flag = 1'b0;
        cell_x = '0; cell_y = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_state", 128'(state), 128'(ST_INI));
        chk("rst_gen", 128'(gen_flag), 128'(1'b0));
        chk("rst_started", 128'(started), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_field", 128'(field), 128'(0));
        chk("rst_score", 128'(score), 128'(0));
        chk("rst_lines", 128'(lines), 128'(0));

        do_start();
        for (int i = 0; i <= 3; i++) apply(i);

        // LOST ignores Start; held Ack gives one move to INI which then waits.
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("lost_start_ignored", 128'(state), 128'(ST_LOST));
        chk("lost_field_frozen", 128'(field), 128'(rm(0, 10'h300)));
        Ack = 1'b1;
        @(negedge Clk);
        chk("ack_to_ini", 128'(state), 128'(ST_INI));
        @(negedge Clk);
        chk("ack_held_ini", 128'(state), 128'(ST_INI));
        chk("ini_field_clr", 128'(field), 128'(0));
        chk("ini_score_clr", 128'(score), 128'(0));
        chk("ini_lines_clr", 128'(lines), 128'(0));
        Ack = 1'b0;
        do_start();

        for (int i = 4; i <= 19; i++) apply(i);

        // Rows 0 and 1 become full; reset lands after both clears, before SCORE.
        cell_x   = 16'h9898;
        cell_y   = 16'h1100;
        lock_req = 1'b1;
        @(negedge Clk);
        lock_req = 1'b0;
        repeat (3) @(negedge Clk);
        chk("clr2_state", 128'(state), 128'(ST_CLEAR));
        chk("clr2_field", 128'(field), 128'(rm(3, 10'h007) | rm(4, 10'h060)));
        Reset = 1'b1;
        #1;
        chk("midclr_rst_state", 128'(state), 128'(ST_INI));
        chk("midclr_rst_field", 128'(field), 128'(0));
        chk("midclr_rst_score", 128'(score), 128'(0));
        chk("midclr_rst_lines", 128'(lines), 128'(0));
        chk("midclr_rst_busy", 128'(busy), 128'(1'b0));
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("post_rst_idle", 128'(state), 128'(ST_INI));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tetris_field.md
# tetris_field

Parametrised Tetris playfield controller: holds the occupancy grid, commits a landed piece, clears any number of full rows with correct gravity, and keeps score and line count. Sits between the piece/movement logic (which supplies cell coordinates and the lock request) and the VGA renderer (which reads the flattened grid). Successor to the fixed 10×12 single-line-clear array. Adds:
- generic size
- multi-line clears with a combo score table
- overlap-based top-out detection
- a lines counter

## Interface
Parameters:
- COLS, 10, playfield width in cells (≤16)
- ROWS, 12, playfield height in cells (≤16)
- SCORE_W, 16, score width in bits
- LINE_PTS, 10, base points per line

Ports (name, direction, width, meaning):
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high
- Start  in  1  leave INI and begin play
- Ack  in  1  leave LOST and return to INI
- lock_req  in  1  piece has landed; commit cells (sampled in MOVE only)
- top_flag  in  1  external top-out indication (sampled in MOVE only)
- cell_x  in  16  four 4-bit x coords; cell i at [4i+3:4i]
- cell_y  in  16  four 4-bit y coords; same packing; y=0 is the bottom row
- field  out  COLS*ROWS  occupancy; bit r*COLS+c is row r, column c
- state  out  7  one-hot state vector
- gen_flag  out  1  high in GEN
- started  out  1  high in any state other than INI
- busy  out  1  high in LOCK, CLEAR or SCORE
- score  out  SCORE_W  accumulated score, saturating
- lines  out  16  total lines cleared, saturating

## Operation
States: INI, GEN, MOVE, LOCK, CLEAR, SCORE, LOST.

- **INI**
  - field, score, lines and the combo count are held at 0.
  - Start → GEN.
- **GEN**
  - One cycle with gen_flag=1, then → MOVE.
- **MOVE**
  - top_flag=1 → LOST. top_flag has priority over lock_req.
  - Otherwise lock_req=1 → LOCK, with the four coordinates latched.
- **LOCK** (one cycle)
  - A cell with x≥COLS or y≥ROWS is discarded.
  - If any in-range cell is already set in field → LOST. Nothing is written.
  - Otherwise all in-range cells are set, the row pointer r=0, the combo count k=0, and the block → CLEAR.
  - Duplicate coordinates are legal and set the bit once.
- **CLEAR** (one row per cycle)
  - If row r is all ones:
    - rows r+1..ROWS-1 each move down one row;
    - row ROWS-1 becomes 0;
    - k increments;
    - r is held, so the row that dropped into r is re-examined.
  - Otherwise r increments.
  - When r reaches ROWS → SCORE.
- **SCORE** (one cycle)
  - score += LINE_PTS × {0,1,3,5,8}[k]; k>4 uses 8.
  - lines += k.
  - Both saturate at all-ones.
  - → GEN.
- **LOST**
  - field, score and lines are frozen.
  - Ack → INI.
  - Start is ignored.

Arithmetic:
- The score addend is computed at SCORE_W+1 bits.
- Overflow clamps score to 2^SCORE_W−1.

## Timing
Reset values:
- state=INI, gen_flag=0, started=0, busy=0.
- field=0, score=0, lines=0.

Latency and timing rules:
- All outputs are registered except gen_flag, started and busy, which are decoded from state.
- lock_req accepted at edge n:
  - LOCK during cycle n+1;
  - field updated at edge n+2;
  - CLEAR for ROWS+k cycles;
  - SCORE for 1 cycle;
  - gen_flag high ROWS+k+3 cycles after acceptance.
- lock_req and top_flag are don't-care outside MOVE. The upstream block must hold the piece stable until gen_flag.
- Reset in any state, including mid-CLEAR, returns immediately to the reset values. No partial shift survives.
- Start and Ack are level-sensitive. Holding Ack high in LOST gives a single transition to INI; INI then waits for Start.

## Structure
- Shared package holds:
  - the state encoding localparams;
  - the combo score table;
  - a function computing the flat index r*COLS+c.
- One natural sub-module, **field_row_shift**. It is combinational: given field and r, it returns the field with row r removed and a zero row inserted at the top. CLEAR instantiates it once.

## Test plan
- Reset, Start, one GEN cycle, MOVE:
  - lock cells (0,0),(1,0),(2,0),(3,0);
  - field bits 0–3 set, score=0, gen_flag returns after ROWS+3 cycles.
- Bottom row pre-filled except columns 8–9, then lock a piece covering (8,0),(9,0),(8,1),(9,1):
  - one line cleared;
  - row 0 then holds only bits 8,9;
  - score=10, lines=1.
- Rows 0–3 filled to COLS−1 columns with column 9 empty, then lock a vertical I at x=9, y=0..3:
  - score=80, lines=4, field=0.
- Lock a piece overlapping an occupied cell:
  - LOST one cycle after LOCK, field unchanged;
  - Ack → INI, field and score cleared.
- Cell y=15 with ROWS=12:
  - that cell is ignored and the other three are written.
- Reset asserted during CLEAR with k=2:
  - state=INI, field=0, score=0 immediately.
